// File: rtl/ksa_pkg.sv
// Shared constants for the Kogge-Stone adder family.
package ksa_pkg;
   localparam int KSA_WIDTH  = 32;
   localparam int KSA_LEVELS = 5;
endpackage

// File: rtl/ksa_prefix_cell.sv
// Kogge-Stone prefix operator: merges a high group (g_hi, p_hi) with the adjacent low group.
// Latency: purely combinational.
// Backpressure: none; the cell is a stateless function of its inputs.
module ksa_prefix_cell (
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   input  logic p_lo,
   output logic g_out,
   output logic p_out
);
   assign g_out = g_hi | (p_hi & g_lo);
   assign p_out = p_hi & p_lo;
endmodule

// File: rtl/ksa32_top.sv
// 32-bit Kogge-Stone adder (cin = 0) producing sum, unsigned carry-out and signed overflow.
// Latency: 1 cycle, result registered on every rising clk edge.
// Backpressure: none; a new operand pair is accepted every cycle.
module ksa32_top
   import ksa_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [KSA_WIDTH-1:0] A,
   input  logic [KSA_WIDTH-1:0] B,
   output logic [KSA_WIDTH-1:0] SUM,
   output logic                 COUT,
   output logic                 overflow
);
   // Level 0 holds the per-bit generate/propagate; level L holds group terms spanning 2^L bits.
   logic [KSA_WIDTH-1:0] g_lv [KSA_LEVELS+1];
   logic [KSA_WIDTH-1:0] p_lv [KSA_LEVELS+1];
   logic [KSA_WIDTH-1:0] p_bit;
   logic [KSA_WIDTH:0]   carry;
   logic [KSA_WIDTH-1:0] sum_c;
   logic                 cout_c;
   logic                 ovf_c;

   assign p_bit    = A ^ B;
   assign g_lv[0]  = A & B;
   assign p_lv[0]  = p_bit;

   genvar lv, i;
   generate
      for (lv = 0; lv < KSA_LEVELS; lv++) begin : g_level
         localparam int SPAN = 1 << lv;
         for (i = 0; i < KSA_WIDTH; i++) begin : g_bit
            if (i >= SPAN) begin : g_cell
               ksa_prefix_cell u_cell (
                  .g_hi  (g_lv[lv][i]),
                  .p_hi  (p_lv[lv][i]),
                  .g_lo  (g_lv[lv][i-SPAN]),
                  .p_lo  (p_lv[lv][i-SPAN]),
                  .g_out (g_lv[lv+1][i]),
                  .p_out (p_lv[lv+1][i])
               );
            end else begin : g_pass
               assign g_lv[lv+1][i] = g_lv[lv][i];
               assign p_lv[lv+1][i] = p_lv[lv][i];
            end
         end
      end
   endgenerate

   // After the last level, G[i] is the carry out of bits [i:0].
   assign carry  = {g_lv[KSA_LEVELS], 1'b0};
   assign sum_c  = p_bit ^ carry[KSA_WIDTH-1:0];
   assign cout_c = carry[KSA_WIDTH];
   assign ovf_c  = carry[KSA_WIDTH-1] ^ carry[KSA_WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         SUM      <= '0;
         COUT     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         SUM      <= sum_c;
         COUT     <= cout_c;
         overflow <= ovf_c;
      end
   end
endmodule

// File: tb/tb_ksa32_top.sv
// Self-checking bench for ksa32_top: directed vector table, reset sequences and random stream.
module tb_ksa32_top;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] a   = '0;
   logic [31:0] b   = '0;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;

   int n_chk  = 0;
   int n_fail = 0;

   // Expected result packed as {cout, overflow, sum}.
   logic [33:0] exp_q [$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [33:0] exp;
   } vec_t;

   ksa32_top dut (
      .clk      (clk),
      .rst      (rst),
      .A        (a),
      .B        (b),
      .SUM      (sum),
      .COUT     (cout),
      .overflow (ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y);
      logic [32:0] s;
      logic        v;
      s = {1'b0, x} + {1'b0, y};
      v = (x[31] == y[31]) && (s[31] != x[31]);
      return {s[32], v, s[31:0]};
   endfunction

   task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got cout=%b ovf=%b sum=%h, want cout=%b ovf=%b sum=%h",
                  name, act[33], act[32], act[31:0], exp[33], exp[32], exp[31:0]);
      end
   endtask

   task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [33:0] exp);
      @(negedge clk);
      a = x;
      b = y;
      exp_q.push_back(exp);
   endtask

   task automatic sample(input string name);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: scoreboard empty when output sampled", name);
      end else begin
         chk(name, {cout, ovf, sum}, exp_q.pop_front());
      end
   endtask

   initial begin
      vec_t vecs [6];
      vecs[0] = '{32'hAAAAAAAA, 32'h55555555, {1'b0, 1'b0, 32'hFFFFFFFF}};
      vecs[1] = '{32'hFFFFFFFF, 32'h00000001, {1'b1, 1'b0, 32'h00000000}};
      vecs[2] = '{32'h7FFFFFFF, 32'h00000001, {1'b0, 1'b1, 32'h80000000}};
      vecs[3] = '{32'h80000000, 32'h80000000, {1'b1, 1'b1, 32'h00000000}};
      vecs[4] = '{32'h12345678, 32'h9ABCDEF0, {1'b0, 1'b0, 32'hACF13568}};
      vecs[5] = '{32'h00000000, 32'h00000000, {1'b0, 1'b0, 32'h00000000}};

      // Reset held with operands that would otherwise produce a carry-out.
      a = 32'hFFFFFFFF;
      b = 32'h00000001;
      #2 rst = 1'b1;
      #1 chk("reset_async", {cout, ovf, sum}, 34'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1 chk("reset_hold", {cout, ovf, sum}, 34'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back({1'b1, 1'b0, 32'h0});
      sample("reset_release");

      // Directed table, operands change every cycle.
      for (int k = 0; k < 6; k++) begin
         drive(vecs[k].a, vecs[k].b, vecs[k].exp);
         sample($sformatf("vec%0d", k));
      end

      // Async reset between edges discards the in-flight result.
      drive(32'h40000000, 32'h40000000, {1'b0, 1'b1, 32'h80000000});
      sample("pre_rst");
      drive(32'h0000FFFF, 32'h00000001, model(32'h0000FFFF, 32'h00000001));
      #2 rst = 1'b1;
      #1 chk("midrst_async", {cout, ovf, sum}, 34'd0);
      exp_q.delete();
      @(posedge clk);
      #1 chk("midrst_hold", {cout, ovf, sum}, 34'd0);
      @(negedge clk);
      rst = 1'b0;
      a = 32'hDEADBEEF;
      b = 32'h21524111;
      exp_q.push_back({1'b1, 1'b0, 32'h00000000});
      sample("post_rst");

      // Random back-to-back stream against the reference model.
      for (int k = 0; k < 10000; k++) begin
         logic [31:0] x;
         logic [31:0] y;
         x = $urandom;
         y = $urandom;
         if (k % 16 == 0) y = ~x;
         drive(x, y, model(x, y));
         sample("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
